truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 161 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose:
//   Holds N_OUT independently configured Boolean functions of N_IN inputs,
//   each stored as a truth table. On request it sweeps every input vector
//   from 0 up to 2**N_IN-1. Each vector and the values of all functions are
//   presented on a valid/ready stream. For each channel it counts how many
//   accepted beats had the function equal to 1.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   cfg_we     in   write strobe for one channel truth table (IDLE only)
//   cfg_sel    in   channel index to write; values >= N_OUT are ignored
//   cfg_tt     in   truth table, bit i = f(vec == i), vec bit0 = x0
//   start      in   one-cycle sweep request (ignored while busy)
//   busy       out  high whenever the sweeper is not idle
//   out_valid  out  a vector/result beat is being presented
//   out_ready  in   downstream accepts the current beat
//   out_vec    out  current input vector {x(N_IN-1)..x0}
//   out_f      out  out_f[k] = tt[k][out_vec]
//   done       out  one-cycle pulse at sweep completion
//   ones_cnt   out  per-channel ones count, channel k at [k*CW +: CW]
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter  int N_IN  = 2,
  parameter  int N_OUT = 5,
  localparam int TT_W  = 2 ** N_IN,
  localparam int CW    = N_IN + 1,
  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [TT_W-1:0]       cfg_tt,
  input  logic                  start,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_IN-1:0]       out_vec,
  output logic [N_OUT-1:0]      out_f,
  output logic                  done,
  output logic [N_OUT*CW-1:0]   ones_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FIN   = 2'd2
  } state_e;

  // Last vector of the sweep; reaching it moves to FIN instead of wrapping.
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;

  // Qualified events shared by every channel.
  logic start_acc;   // start seen while idle
  logic cfg_acc;     // table write seen while idle
  logic beat_acc;    // current beat accepted downstream

  assign start_acc = (state_q == IDLE)  && start;
  assign cfg_acc   = (state_q == IDLE)  && cfg_we;
  assign beat_acc  = (state_q == SWEEP) && out_ready;

  // ---------------------------------------------------------------------------
  // Sequencer: next-state and vector counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          vec_d   = '0;
        end
      end
      SWEEP: begin
        if (out_ready) begin
          // On the final beat the vector is left at its last value, so no
          // wrapped vector is ever presented.
          if (vec_q == VEC_LAST) begin
            state_d = FIN;
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // Handshake outputs decode the registered state only, so out_ready never
  // reaches them combinationally.
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == SWEEP);
  assign done      = (state_q == FIN);
  assign out_vec   = vec_q;

  // ---------------------------------------------------------------------------
  // Per-channel truth table, function output and ones counter
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
    logic [TT_W-1:0] tt_q;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Tables only change while idle. A cfg_sel at or above N_OUT matches no
    // channel and is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        tt_q <= '0;
      end else if (cfg_acc && (cfg_sel == SEL_W'(gi))) begin
        tt_q <= cfg_tt;
      end
    end

    // Zero-latency lookup of the registered vector into the table.
    assign out_f[gi] = tt_q[vec_q];

    // CW = N_IN+1 bits hold TT_W, the count when every vector yields 1.
    always_comb begin
      cnt_d = cnt_q;
      if (start_acc) begin
        cnt_d = '0;
      end else if (beat_acc) begin
        cnt_d = cnt_q + CW'(out_f[gi]);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign ones_cnt[gi*CW +: CW] = cnt_q;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Purpose:
//   Self-checking bench for truth_table_sweeper. DUT A uses the default
//   parameters (N_IN=2, N_OUT=5). DUT B uses N_IN=3, N_OUT=1. The reference
//   model keeps a copy of every table. It predicts each beat from the table
//   bit at the expected vector. It predicts final counts as the popcount of
//   each table.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- DUT A
  logic        a_rst, a_cfg_we, a_start, a_busy, a_out_valid, a_out_ready, a_done;
  logic [2:0]  a_cfg_sel;
  logic [3:0]  a_cfg_tt;
  logic [1:0]  a_out_vec;
  logic [4:0]  a_out_f;
  logic [14:0] a_ones_cnt;

  truth_table_sweeper #(.N_IN(2), .N_OUT(5)) u_dut_a (
    .clk       (clk),
    .rst       (a_rst),
    .cfg_we    (a_cfg_we),
    .cfg_sel   (a_cfg_sel),
    .cfg_tt    (a_cfg_tt),
    .start     (a_start),
    .busy      (a_busy),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_vec   (a_out_vec),
    .out_f     (a_out_f),
    .done      (a_done),
    .ones_cnt  (a_ones_cnt)
  );

  // ---------------------------------------------------------------- DUT B
  logic        b_rst, b_cfg_we, b_start, b_busy, b_out_valid, b_out_ready, b_done;
  logic [0:0]  b_cfg_sel;
  logic [7:0]  b_cfg_tt;
  logic [2:0]  b_out_vec;
  logic [0:0]  b_out_f;
  logic [3:0]  b_ones_cnt;

  truth_table_sweeper #(.N_IN(3), .N_OUT(1)) u_dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .cfg_we    (b_cfg_we),
    .cfg_sel   (b_cfg_sel),
    .cfg_tt    (b_cfg_tt),
    .start     (b_start),
    .busy      (b_busy),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_vec   (b_out_vec),
    .out_f     (b_out_f),
    .done      (b_done),
    .ones_cnt  (b_ones_cnt)
  );

  // ---------------------------------------------------------------- model A
  logic [3:0] m_tt [5];
  int         run_cnt [5];

  function automatic logic [4:0] exp_f(input int v);
    logic [4:0] r;
    for (int k = 0; k < 5; k++) r[k] = m_tt[k][v];
    return r;
  endfunction

  function automatic logic [14:0] pack_running();
    logic [14:0] r = '0;
    for (int k = 0; k < 5; k++) r[k*3 +: 3] = 3'(run_cnt[k]);
    return r;
  endfunction

  function automatic logic [14:0] pack_final();
    logic [14:0] r = '0;
    for (int k = 0; k < 5; k++) r[k*3 +: 3] = 3'($countones(m_tt[k]));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input int sel, input logic [3:0] tt);
    a_cfg_we  = 1'b1;
    a_cfg_sel = 3'(sel);
    a_cfg_tt  = tt;
    tick();
    a_cfg_we  = 1'b0;
    if (sel < 5) m_tt[sel] = tt;
  endtask

  task automatic a_clear_model();
    for (int k = 0; k < 5; k++) begin
      m_tt[k]    = '0;
      run_cnt[k] = 0;
    end
  endtask

  // mode: 0 = ready always high, 1 = ready pattern 1,0,0 repeating,
  //       2 = random ready. inject: attempt a ch2 write mid-sweep.
  // rst_at: beat index on which reset is asserted (-1 for none).
  task automatic a_sweep(input string name, input int mode, input bit inject, input int rst_at);
    int  beat, cyc, phase;
    bit  rdy, injected;
    for (int k = 0; k < 5; k++) run_cnt[k] = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    beat = 0; cyc = 0; phase = 0; injected = 1'b0;
    while (beat < 4 && cyc < 100) begin
      a_cfg_we = 1'b0;
      check_eq({name, ".valid"}, 64'(a_out_valid), 64'(1));
      check_eq({name, ".busy"},  64'(a_busy),      64'(1));
      check_eq({name, ".done"},  64'(a_done),      64'(0));
      check_eq({name, ".vec"},   64'(a_out_vec),   64'(beat));
      check_eq({name, ".f"},     64'(a_out_f),     64'(exp_f(beat)));
      check_eq({name, ".cnt"},   64'(a_ones_cnt),  64'(pack_running()));
      if (rst_at == beat) begin
        a_rst = 1'b1; a_out_ready = 1'b1;
        tick();
        a_rst = 1'b0;
        a_clear_model();
        check_eq({name, ".rst_valid"}, 64'(a_out_valid), 64'(0));
        check_eq({name, ".rst_busy"},  64'(a_busy),      64'(0));
        check_eq({name, ".rst_cnt"},   64'(a_ones_cnt),  64'(0));
        check_eq({name, ".rst_f"},     64'(a_out_f),     64'(0));
        check_eq({name, ".rst_vec"},   64'(a_out_vec),   64'(0));
        for (int i = 0; i < 4; i++) begin
          check_eq({name, ".rst_nodone"}, 64'(a_done), 64'(0));
          tick();
        end
        $display("sweep %s aborted by reset at beat %0d", name, beat);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (phase % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
      if (inject && beat == 1 && !injected) begin
        a_cfg_we = 1'b1; a_cfg_sel = 3'd2; a_cfg_tt = 4'b1111;
        injected = 1'b1;
      end
      a_out_ready = rdy;
      tick();
      cyc++;
      if (rdy) begin
        for (int k = 0; k < 5; k++) run_cnt[k] += int'(m_tt[k][beat]);
        beat++;
      end
    end
    a_cfg_we = 1'b0;
    check_eq({name, ".no_timeout"}, 64'(cyc < 100), 64'(1));
    if (mode == 0) check_eq({name, ".latency"}, 64'(cyc), 64'(4));
    check_eq({name, ".fin_done"},  64'(a_done),      64'(1));
    check_eq({name, ".fin_valid"}, 64'(a_out_valid), 64'(0));
    a_out_ready = 1'b1;
    tick();
    check_eq({name, ".idle_done"}, 64'(a_done),     64'(0));
    check_eq({name, ".idle_busy"}, 64'(a_busy),     64'(0));
    check_eq({name, ".final_cnt"}, 64'(a_ones_cnt), 64'(pack_final()));
    tick();
    check_eq({name, ".hold_cnt"},  64'(a_ones_cnt), 64'(pack_final()));
    $display("sweep %s mode=%0d cycles=%0d ones_cnt=%0h", name, mode, cyc, a_ones_cnt);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int b_beat, b_cyc, b_run;
    bit b_rdy, b_started;
    a_rst = 1'b1; a_cfg_we = 1'b0; a_cfg_sel = '0; a_cfg_tt = '0; a_start = 1'b0; a_out_ready = 1'b1;
    b_rst = 1'b1; b_cfg_we = 1'b0; b_cfg_sel = '0; b_cfg_tt = '0; b_start = 1'b0; b_out_ready = 1'b1;
    a_clear_model();
    repeat (3) tick();
    a_rst = 1'b0; b_rst = 1'b0;

    check_eq("reset.busy",  64'(a_busy),      64'(0));
    check_eq("reset.valid", 64'(a_out_valid), 64'(0));
    check_eq("reset.done",  64'(a_done),      64'(0));
    check_eq("reset.cnt",   64'(a_ones_cnt),  64'(0));
    check_eq("reset.f",     64'(a_out_f),     64'(0));
    check_eq("reset.vec",   64'(a_out_vec),   64'(0));
    check_eq("reset.b_busy", 64'(b_busy),     64'(0));

    // Reference configuration, ready always high.
    a_write(0, 4'b1111); a_write(1, 4'b1011); a_write(2, 4'b0110);
    a_write(3, 4'b0001); a_write(4, 4'b0100);
    a_sweep("ref", 0, 1'b0, -1);
    check_eq("ref.cnt_const", 64'(a_ones_cnt), 64'(15'd4764));

    // Same config with stalls.
    a_sweep("stall", 1, 1'b0, -1);
    check_eq("stall.cnt_const", 64'(a_ones_cnt), 64'(15'd4764));

    // Write during sweep is ignored; the same write in idle takes effect.
    a_sweep("inject", 0, 1'b1, -1);
    check_eq("inject.ch2", 64'(a_ones_cnt[8:6]), 64'(2));
    a_write(2, 4'b1111);
    a_sweep("rerun", 0, 1'b0, -1);
    check_eq("rerun.ch2", 64'(a_ones_cnt[8:6]), 64'(4));

    // Out-of-range channel write is dropped.
    a_write(7, 4'b0000); a_write(5, 4'b0000);
    a_sweep("oob", 2, 1'b0, -1);

    // Random tables and random backpressure.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 5; k++) a_write(k, 4'($urandom_range(0, 15)));
      a_sweep("rand", 2, 1'b0, -1);
    end

    // Reset on the third beat, then confirm tables were cleared.
    a_sweep("abort", 0, 1'b0, 2);
    a_sweep("zero", 0, 1'b0, -1);

    // Reset outranks start and cfg_we in the same cycle.
    a_rst = 1'b1; a_start = 1'b1; a_cfg_we = 1'b1; a_cfg_sel = 3'd0; a_cfg_tt = 4'b1111;
    tick();
    a_rst = 1'b0; a_start = 1'b0; a_cfg_we = 1'b0;
    check_eq("prio.busy", 64'(a_busy), 64'(0));
    tick();
    check_eq("prio.busy2", 64'(a_busy), 64'(0));
    a_sweep("prio", 0, 1'b0, -1);

    // DUT B: table write and start in the same cycle, all-ones table,
    // start pulsed again mid-sweep.
    b_cfg_we = 1'b1; b_cfg_sel = 1'b0; b_cfg_tt = 8'hFF; b_start = 1'b1;
    tick();
    b_cfg_we = 1'b0; b_start = 1'b0;
    b_beat = 0; b_cyc = 0; b_run = 0; b_started = 1'b0;
    while (b_beat < 8 && b_cyc < 200) begin
      b_start = 1'b0;
      check_eq("b.valid", 64'(b_out_valid), 64'(1));
      check_eq("b.vec",   64'(b_out_vec),   64'(b_beat));
      check_eq("b.f",     64'(b_out_f),     64'(1));
      check_eq("b.cnt",   64'(b_ones_cnt),  64'(b_run));
      if (b_beat == 3 && !b_started) begin
        b_start = 1'b1; b_started = 1'b1;
      end
      b_rdy = 1'($urandom_range(0, 1));
      b_out_ready = b_rdy;
      tick();
      b_cyc++;
      if (b_rdy) begin
        b_run++;
        b_beat++;
      end
    end
    b_start = 1'b0;
    check_eq("b.no_timeout", 64'(b_cyc < 200), 64'(1));
    check_eq("b.fin_done",   64'(b_done),      64'(1));
    tick();
    check_eq("b.idle_busy",  64'(b_busy),      64'(0));
    check_eq("b.final_cnt",  64'(b_ones_cnt),  64'(8));
    tick();
    check_eq("b.no_restart", 64'(b_busy),      64'(0));
    $display("sweep b cycles=%0d ones_cnt=%0d", b_cyc, b_ones_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
